// File: rtl/setup_ctrl_pkg.sv
// Purpose : shared types and constants for the lock setup sequencer.
// Contents: keypad/display packet types, configuration record, FSM state enum,
//           fill-pattern commands and the power-on configuration.
package setup_ctrl_pkg;

  // 20 keypad digits, digit 19 first-entered / most significant
  typedef logic [19:0][3:0] senhaPac_t;
  // 6 display digits, BCD5 is the leftmost (bits 23:20)
  typedef logic [5:0][3:0]  bcdPac_t;

  typedef struct packed {
    logic       bip_status;
    logic [6:0] bip_time;
    logic [6:0] tranca_aut_time;
    senhaPac_t  senha_master;
    senhaPac_t  senha_1;
    senhaPac_t  senha_2;
    senhaPac_t  senha_3;
    senhaPac_t  senha_4;
  } setupPac_t;

  typedef enum logic [2:0] {OPER, AUTH, START, SETUP, DRAIN} ctrl_estado_t;

  localparam senhaPac_t SENHA_VAZIA    = {20{4'hF}};
  localparam senhaPac_t CMD_SAVE       = {20{4'hB}};
  localparam senhaPac_t CMD_NULO       = {20{4'hE}};
  localparam senhaPac_t MASTER_DEFAULT = {{16{4'hF}}, 4'h1, 4'h2, 4'h3, 4'h4};

  localparam setupPac_t CFG_DEFAULT = '{
    bip_status:      1'b1,
    bip_time:        7'd5,
    tranca_aut_time: 7'd5,
    senha_master:    MASTER_DEFAULT,
    senha_1:         SENHA_VAZIA,
    senha_2:         SENHA_VAZIA,
    senha_3:         SENHA_VAZIA,
    senha_4:         SENHA_VAZIA
  };

  // Display shown while waiting for the master password: "A" then blanks
  localparam bcdPac_t BCD_AUTH  = 24'hAFFFFF;
  // Cycles to wait for setup to answer a forced save before giving up
  localparam int      DRAIN_MAX = 4;

  function automatic logic is_fill(input senhaPac_t v, input logic [3:0] d);
    return v == {20{d}};
  endfunction

endpackage

// File: rtl/setup_ctrl_timer.sv
// Purpose : loadable down-counter that parks at zero and flags it.
// Latency : load takes effect on the next edge; decrements once per cycle while nonzero.
// Ports   : clk/rst, i_load + i_load_val (load wins over decrement), o_zero.
module ctrl_timer #(
  parameter int MAX_VAL = 1,
  parameter int W       = $clog2(MAX_VAL + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  output logic         o_zero
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/setup_ctrl.sv
// Purpose : owns the live config; gates setup behind master password with retry
//           lockout and inactivity timeout; muxes keypad/display between paths.
// Latency : routing is combinational; state changes, setup_on and cfg_update are
//           registered (setup_on one cycle after the matching master packet).
// Flow    : no backpressure; packets are strobes, ignored ones are simply dropped.
// Ports   : keypad in (digitos_*), operational path (oper_*), setup path (setup_*,
//           data_setup_*), muxed display (bcd_pac/display_en), cfg/cfg_update/setup_active.
module setup_ctrl
  import setup_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 30000,
  parameter int MAX_FAIL       = 3,
  parameter int LOCKOUT_CYCLES = 60000
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      setup_req,
  input  senhaPac_t digitos_value,
  input  logic      digitos_valid,
  input  bcdPac_t   oper_bcd_pac,
  input  logic      oper_display_en,
  output senhaPac_t oper_digitos_value,
  output logic      oper_digitos_valid,
  output logic      setup_on,
  output senhaPac_t setup_digitos_value,
  output logic      setup_digitos_valid,
  input  bcdPac_t   setup_bcd_pac,
  input  logic      setup_display_en,
  input  setupPac_t data_setup_new,
  input  logic      data_setup_ok,
  output bcdPac_t   bcd_pac,
  output logic      display_en,
  output setupPac_t cfg,
  output logic      cfg_update,
  output logic      setup_active
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam int LW = $clog2(LOCKOUT_CYCLES + 1);
  localparam int FW = $clog2(MAX_FAIL + 1);
  localparam int DW = $clog2(DRAIN_MAX);

  ctrl_estado_t  r_state;
  logic [FW-1:0] r_fail_cnt;
  logic [DW-1:0] r_drain_cnt;
  logic          r_setup_on;
  logic          r_cfg_update;
  setupPac_t     r_cfg;

  logic w_in_timed, w_tmr_load, w_tmr_zero, w_timeout;
  logic w_lock_zero, w_lock_load;
  logic w_key_skip, w_key_cancel, w_key_match, w_auth_bad, w_force_save;

  // The inactivity timer is held at full scale outside AUTH/SETUP, so it is
  // already primed on the first cycle of either state; any key restarts it.
  assign w_in_timed = (r_state == AUTH) || (r_state == SETUP);
  assign w_tmr_load = !w_in_timed || digitos_valid;
  assign w_timeout  = w_in_timed && w_tmr_zero;

  assign w_key_skip   = is_fill(digitos_value, 4'hE) || is_fill(digitos_value, 4'hF);
  assign w_key_cancel = is_fill(digitos_value, 4'hB);
  assign w_key_match  = (digitos_value == r_cfg.senha_master);
  assign w_auth_bad   = (r_state == AUTH) && digitos_valid &&
                        !w_key_skip && !w_key_cancel && !w_key_match;
  assign w_lock_load  = w_auth_bad && (r_fail_cnt == FW'(MAX_FAIL - 1));

  // On SETUP timeout, inject a save command so setup flushes cleanly; a real
  // key or a result arriving in the same cycle takes precedence.
  assign w_force_save = (r_state == SETUP) && w_timeout && !digitos_valid && !data_setup_ok;

  ctrl_timer #(.MAX_VAL(TIMEOUT_CYCLES - 1)) u_inact_tmr (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_tmr_load),
    .i_load_val (TW'(TIMEOUT_CYCLES - 1)),
    .o_zero     (w_tmr_zero)
  );

  ctrl_timer #(.MAX_VAL(LOCKOUT_CYCLES)) u_lock_cnt (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_lock_load),
    .i_load_val (LW'(LOCKOUT_CYCLES)),
    .o_zero     (w_lock_zero)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= OPER;
      r_fail_cnt   <= '0;
      r_drain_cnt  <= '0;
      r_setup_on   <= 1'b0;
      r_cfg_update <= 1'b0;
      r_cfg        <= CFG_DEFAULT;
    end else begin
      r_setup_on   <= 1'b0;
      r_cfg_update <= 1'b0;
      case (r_state)
        OPER: begin
          if (setup_req && w_lock_zero) r_state <= AUTH;
        end
        AUTH: begin
          if (digitos_valid) begin
            if (w_key_skip) begin
              r_state <= AUTH;
            end else if (w_key_cancel) begin
              r_state <= OPER;
            end else if (w_key_match) begin
              r_fail_cnt <= '0;
              r_setup_on <= 1'b1;
              r_state    <= START;
            end else if (w_lock_load) begin
              r_fail_cnt <= '0;
              r_state    <= OPER;
            end else begin
              r_fail_cnt <= r_fail_cnt + 1'b1;
            end
          end else if (w_timeout) begin
            r_state <= OPER;
          end
        end
        START: r_state <= SETUP;
        SETUP: begin
          if (data_setup_ok) begin
            r_cfg        <= data_setup_new;
            r_cfg_update <= 1'b1;
            r_state      <= OPER;
          end else if (w_force_save) begin
            r_drain_cnt <= '0;
            r_state     <= DRAIN;
          end
        end
        DRAIN: begin
          if (data_setup_ok || (r_drain_cnt == DW'(DRAIN_MAX - 1))) begin
            r_state <= OPER;
          end else begin
            r_drain_cnt <= r_drain_cnt + 1'b1;
          end
        end
        default: r_state <= OPER;
      endcase
    end
  end

  always_comb begin
    oper_digitos_value  = digitos_value;
    oper_digitos_valid  = 1'b0;
    setup_digitos_value = digitos_value;
    setup_digitos_valid = 1'b0;
    bcd_pac             = oper_bcd_pac;
    display_en          = oper_display_en;
    case (r_state)
      OPER: oper_digitos_valid = digitos_valid;
      AUTH: begin
        bcd_pac    = BCD_AUTH;
        display_en = 1'b1;
      end
      START, SETUP, DRAIN: begin
        setup_digitos_valid = digitos_valid;
        bcd_pac             = setup_bcd_pac;
        display_en          = setup_display_en;
        if (w_force_save) begin
          setup_digitos_value = CMD_SAVE;
          setup_digitos_valid = 1'b1;
        end
      end
      default: begin
        bcd_pac    = BCD_AUTH;
        display_en = 1'b1;
      end
    endcase
  end

  assign setup_on     = r_setup_on;
  assign cfg_update   = r_cfg_update;
  assign cfg          = r_cfg;
  assign setup_active = (r_state != OPER);

endmodule
